assoc2_wt_cache: RTL and testbench
==================================

// Module: assoc2_wt_cache
// PURPOSE
//  2-way set-associative, write-through, no-write-allocate data cache with LRU replacement.
//  Sits between the memory-stage load/store unit and data_mem. Has an explicit request/response
//  handshake and a miss FSM, so the pipeline stalls while main memory is accessed.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  word width; only 32 is supported (elaboration $error otherwise)
//  NUM_SETS    8   sets per way; must be a power of 2 and >=2
//  CNT_WIDTH   32  width of the hit and miss statistics counters
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous, active-low reset
//  req_valid      in   1           CPU request present
//  req_ready      out  1           cache can accept a request (state==IDLE)
//  req_write      in   1           1 = store, 0 = load
//  addr_mode      in   3           `DATA_ADDR_MODE_{B,BU,W}
//  addr           in   ADDR_WIDTH  byte address
//  write_data     in   DATA_WIDTH  store data; byte stores use bits [7:0]
//  resp_valid     out  1           1-cycle pulse: load data valid, or store complete
//  read_data      out  DATA_WIDTH  load result after extension
//  mem_req        out  1           memory request; held until mem_ack
//  mem_we         out  1           memory write
//  mem_addr       out  ADDR_WIDTH  memory address; word-aligned on fills
//  mem_addr_mode  out  3           W on fills; store mode on writes
//  mem_wdata      out  DATA_WIDTH  store data to memory
//  mem_ack        in   1           memory done; mem_rdata valid in the same cycle
//  mem_rdata      in   DATA_WIDTH  fill word
//  hit_count      out  CNT_WIDTH   saturating count of load hits
//  miss_count     out  CNT_WIDTH   saturating count of load misses
// BEHAVIOUR
//  Address split: tag = addr[AW-1:2+log2(NUM_SETS)], set = addr[2+log2(NUM_SETS)-1:2], off = addr[1:0].
//  Line = valid + tag + 4 bytes. One LRU bit per set; 0 means way0 is the victim.
//  Reset: all valid bits = 0, all LRU bits = 0, FSM = IDLE, counters = 0.
//   Outputs on reset: req_ready = 1; resp_valid = mem_req = mem_we = 0; read_data = 0.
//  Request is accepted on req_valid & req_ready; addr, mode, data and write are latched.
//  FSM states: IDLE, FILL, WRITE.
//  IDLE, load hit (valid & tag match in either way):
//   - read_data is registered; resp_valid = 1 on the next cycle.
//   - LRU points at the way that was not hit; hit_count++. State stays IDLE (back-to-back allowed).
//  IDLE, load miss -> FILL; miss_count++.
//  FILL: mem_req = 1, mem_we = 0, mem_addr = {addr[AW-1:2], 2'b00}, held until mem_ack.
//   - On mem_ack: write the victim way (invalid way0, else invalid way1, else LRU way).
//   - Set valid and tag; LRU points at the other way; extract the result from mem_rdata.
//   - resp_valid next cycle; -> IDLE.
//  IDLE, store -> WRITE. On a store hit, update the hit way in the acceptance cycle:
//   - W writes 4 bytes; B/BU write byte[off] only.
//   - LRU is updated. A store miss does not allocate.
//  WRITE: mem_req = 1, mem_we = 1, latched addr/mode/data, held until mem_ack.
//   - On mem_ack: resp_valid next cycle; -> IDLE.
//  Load extract:
//   - BU: zero-extend byte[off]. B: sign-extend byte[off].
//   - W: {b3,b2,b1,b0}; off is ignored. Any other mode is treated as W.
//  Counters saturate at all-ones and do not wrap.
//  Same-set load after a store: served from the updated line (hit) with no hazard.
//  mem_ack outside FILL/WRITE is ignored.
//  Async reset mid-FILL/WRITE: mem_req drops immediately and no line is written.
// STRUCTURE
//  cache_pkg: state enum, line struct, function extract(mode, off, word).
//  The address-mode macros stay in the existing defines header.
//  Sub-module cache_way: one tag/data/valid array with combinational lookup and byte-enable write.
//   Instantiate it twice; the LRU and the FSM stay in the top level.
// TESTING
//  1 Reset, then LW 0x40 -> miss: mem_req with mem_addr = 0x40; ack with 0xDEADBEEF.
//    resp read_data = 0xDEADBEEF; miss_count = 1.
//  2 LW 0x40 again -> resp 1 cycle after accept; no mem_req; hit_count = 1.
//  3 LB 0x43 -> 0xFFFFFFDE. LBU 0x43 -> 0x000000DE. Both are hits.
//  4 SB 0x41 = 0x55 -> mem_we write with mode B. Then LW 0x40 hit -> 0xDEAD55EF.
//  5 Three addresses in the same set (set 0, NUM_SETS = 8: 0x00, 0x20, 0x40):
//    - load 0x00, load 0x20, reload 0x00, then load 0x40 -> the 0x20 line is evicted.
//    - Reload 0x00 hits; reload 0x20 misses.
//  6 rst_n low while in FILL before mem_ack -> mem_req = 0 at once.
//    After release, LW of the same address misses again.

Source files
------------

// File: rtl/assoc2_wt_cache_pkg.sv
// Shared types and helpers for the 2-way write-through data cache.
package assoc2_wt_cache_pkg;

    // Memory-access mode encodings seen on addr_mode / mem_addr_mode.
    localparam logic [2:0] DATA_ADDR_MODE_B  = 3'b000;
    localparam logic [2:0] DATA_ADDR_MODE_W  = 3'b010;
    localparam logic [2:0] DATA_ADDR_MODE_BU = 3'b100;

    // Miss FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Result of a lookup in one way for the currently selected set.
    typedef struct packed {
        logic        valid;
        logic        hit;
        logic [31:0] data;
    } way_rd_t;

    // Load extraction: byte[off] zero/sign extended, or the whole word.
    function automatic logic [31:0] extract(input logic [2:0]  mode,
                                            input logic [1:0]  off,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        case (mode)
            DATA_ADDR_MODE_B:  res = {{24{b[7]}}, b};
            DATA_ADDR_MODE_BU: res = {24'h00_0000, b};
            default:           res = word;
        endcase
        return res;
    endfunction

    // True for the byte-sized modes.
    function automatic logic is_byte_mode(input logic [2:0] mode);
        return (mode == DATA_ADDR_MODE_B) || (mode == DATA_ADDR_MODE_BU);
    endfunction

endpackage

// File: rtl/assoc2_wt_cache_way.sv
// One cache way: valid/tag/data arrays, combinational lookup, byte-enable write.
module assoc2_wt_cache_way
    import assoc2_wt_cache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int SET_W    = 3,
    parameter int TAG_W    = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SET_W-1:0] lk_set,
    input  logic [TAG_W-1:0] lk_tag,
    output way_rd_t          rd,
    input  logic             wr_en,
    input  logic             wr_fill,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data
);

    logic [NUM_SETS-1:0]             valid_q, valid_d;
    logic [NUM_SETS-1:0][TAG_W-1:0]  tag_q,   tag_d;
    logic [NUM_SETS-1:0][31:0]       data_q,  data_d;

    // Lookup of the selected set.
    always_comb begin
        rd.valid = valid_q[lk_set];
        rd.hit   = valid_q[lk_set] && (tag_q[lk_set] == lk_tag);
        rd.data  = data_q[lk_set];
    end

    // Next-state of the arrays: fills set valid+tag, enabled bytes take new data.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en && wr_fill) begin
            valid_d[lk_set] = 1'b1;
            tag_d[lk_set]   = lk_tag;
        end else begin
            valid_d[lk_set] = valid_q[lk_set];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                data_d[lk_set][8*b +: 8] = wr_data[8*b +: 8];
            end else begin
                data_d[lk_set][8*b +: 8] = data_q[lk_set][8*b +: 8];
            end
        end
    end

    // Array storage; reset invalidates every line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/assoc2_wt_cache.sv
// 2-way set-associative, write-through, no-write-allocate data cache with LRU.
module assoc2_wt_cache
    import assoc2_wt_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            addr_mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [2:0]            mem_addr_mode,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int SET_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - 2 - SET_W;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("assoc2_wt_cache: only DATA_WIDTH = 32 is supported");
    end
    if ((NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0)) begin : g_bad_num_sets
        $error("assoc2_wt_cache: NUM_SETS must be a power of 2 and >= 2");
    end

    state_e                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [2:0]            mode_q,       mode_d;
    logic [NUM_SETS-1:0]   lru_q,        lru_d;
    logic                  req_ready_q,  req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] read_data_q,  read_data_d;
    logic                  mem_req_q,    mem_req_d;
    logic                  mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [2:0]            mem_mode_q,   mem_mode_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q,    hit_cnt_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q,   miss_cnt_d;

    logic [SET_W-1:0]      lk_set_s;
    logic [TAG_W-1:0]      lk_tag_s;
    way_rd_t               rd0_s, rd1_s;
    logic                  wr_en0_s, wr_en1_s, wr_fill_s;
    logic [3:0]            wr_be_s;
    logic [31:0]           wr_data_s;
    logic                  victim_s;

    // In IDLE the live request address is looked up; during a fill the latched one.
    always_comb begin
        if (state_q == ST_IDLE) begin
            lk_set_s = addr[2 +: SET_W];
            lk_tag_s = addr[ADDR_WIDTH-1 -: TAG_W];
        end else begin
            lk_set_s = addr_q[2 +: SET_W];
            lk_tag_s = addr_q[ADDR_WIDTH-1 -: TAG_W];
        end
    end

    assoc2_wt_cache_way #(.NUM_SETS(NUM_SETS), .SET_W(SET_W), .TAG_W(TAG_W)) u_way0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .lk_set  (lk_set_s),
        .lk_tag  (lk_tag_s),
        .rd      (rd0_s),
        .wr_en   (wr_en0_s),
        .wr_fill (wr_fill_s),
        .wr_be   (wr_be_s),
        .wr_data (wr_data_s)
    );

    assoc2_wt_cache_way #(.NUM_SETS(NUM_SETS), .SET_W(SET_W), .TAG_W(TAG_W)) u_way1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .lk_set  (lk_set_s),
        .lk_tag  (lk_tag_s),
        .rd      (rd1_s),
        .wr_en   (wr_en1_s),
        .wr_fill (wr_fill_s),
        .wr_be   (wr_be_s),
        .wr_data (wr_data_s)
    );

    // Fill victim: an invalid way first (way0 preferred), otherwise the LRU way.
    always_comb begin
        if (!rd0_s.valid) begin
            victim_s = 1'b0;
        end else if (!rd1_s.valid) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_q[lk_set_s];
        end
    end

    // Request handling, miss FSM, LRU update and way-write control.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mode_d       = mode_q;
        lru_d        = lru_q;
        resp_valid_d = 1'b0;
        read_data_d  = read_data_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_mode_d   = mem_mode_q;
        mem_wdata_d  = mem_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        wr_en0_s     = 1'b0;
        wr_en1_s     = 1'b0;
        wr_fill_s    = 1'b0;
        wr_be_s      = 4'b0000;
        wr_data_s    = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d = addr;
                    mode_d = addr_mode;
                    if (req_write) begin
                        state_d     = ST_WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr;
                        mem_mode_d  = addr_mode;
                        mem_wdata_d = write_data;
                        if (is_byte_mode(addr_mode)) begin
                            wr_be_s   = 4'b0001 << addr[1:0];
                            wr_data_s = {4{write_data[7:0]}};
                        end else begin
                            wr_be_s   = 4'b1111;
                            wr_data_s = write_data;
                        end
                        if (rd0_s.hit || rd1_s.hit) begin
                            wr_en0_s        = rd0_s.hit;
                            wr_en1_s        = !rd0_s.hit;
                            lru_d[lk_set_s] = rd0_s.hit;
                        end else begin
                            lru_d[lk_set_s] = lru_q[lk_set_s];
                        end
                    end else if (rd0_s.hit || rd1_s.hit) begin
                        resp_valid_d    = 1'b1;
                        read_data_d     = extract(addr_mode, addr[1:0],
                                                  rd0_s.hit ? rd0_s.data : rd1_s.data);
                        lru_d[lk_set_s] = rd0_s.hit;
                        if (hit_cnt_q != '1) begin
                            hit_cnt_d = hit_cnt_q + CNT_ONE;
                        end else begin
                            hit_cnt_d = hit_cnt_q;
                        end
                    end else begin
                        state_d    = ST_FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_mode_d = DATA_ADDR_MODE_W;
                        if (miss_cnt_q != '1) begin
                            miss_cnt_d = miss_cnt_q + CNT_ONE;
                        end else begin
                            miss_cnt_d = miss_cnt_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    wr_fill_s       = 1'b1;
                    wr_be_s         = 4'b1111;
                    wr_data_s       = mem_rdata;
                    wr_en0_s        = !victim_s;
                    wr_en1_s        = victim_s;
                    lru_d[lk_set_s] = !victim_s;
                    read_data_d     = extract(mode_q, addr_q[1:0], mem_rdata);
                    resp_valid_d    = 1'b1;
                    mem_req_d       = 1'b0;
                    mem_we_d        = 1'b0;
                    state_d         = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    resp_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State, latched request, LRU bits, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            mode_q       <= 3'b000;
            lru_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            read_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_mode_q   <= 3'b000;
            mem_wdata_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mode_q       <= mode_d;
            lru_q        <= lru_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            read_data_q  <= read_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_mode_q   <= mem_mode_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign read_data     = read_data_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_addr_mode = mem_mode_q;
    assign mem_wdata     = mem_wdata_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_assoc2_wt_cache.sv
// Randomized bench for assoc2_wt_cache against a resident-list / flat-memory model.
module tb_assoc2_wt_cache;
    import assoc2_wt_cache_pkg::*;

    localparam int CW   = 5;
    localparam int CMAX = 31;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  addr_mode;
    logic [31:0] addr, write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_addr_mode;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [CW-1:0] hit_count, miss_count;

    assoc2_wt_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(8), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .addr_mode(addr_mode), .addr(addr), .write_data(write_data),
        .resp_valid(resp_valid), .read_data(read_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_addr_mode(mem_addr_mode), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [31:0] mem [int unsigned];
    int unsigned res_line [8][2];   // per set, MRU first
    int          res_n [8];
    int          m_hit, m_miss;

    function automatic logic [31:0] mem_get(input int unsigned line);
        if (mem.exists(line)) return mem[line];
        return (line * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit m_is_hit(input int unsigned line);
        int s = int'(line % 8);
        return (res_n[s] >= 1 && res_line[s][0] == line) ||
               (res_n[s] >= 2 && res_line[s][1] == line);
    endfunction

    function automatic void m_touch(input int unsigned line);
        int s = int'(line % 8);
        if (res_n[s] >= 2 && res_line[s][1] == line) begin
            res_line[s][1] = res_line[s][0];
            res_line[s][0] = line;
        end
    endfunction

    function automatic void m_insert(input int unsigned line);
        int s = int'(line % 8);
        res_line[s][1] = res_line[s][0];
        res_line[s][0] = line;
        if (res_n[s] < 2) res_n[s]++;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < 8; s++) res_n[s] = 0;
        m_hit  = 0;
        m_miss = 0;
    endfunction

    function automatic logic [31:0] m_extract(input logic [2:0] md, input int off, input logic [31:0] w);
        logic [31:0] b;
        b = (w >> (8 * off)) & 32'h0000_00FF;
        if (md == DATA_ADDR_MODE_BU) return b;
        if (md == DATA_ADDR_MODE_B)  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        return w;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // One transaction; called and returns at a negedge with the cache idle.
    task automatic do_req(input logic w, input logic [2:0] md, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd);
        int unsigned line;
        int          off;
        bit          hit;
        logic [31:0] word;
        int          d;
        line = a >> 2;
        off  = int'(a & 32'd3);
        hit  = m_is_hit(line);
        rd   = 32'h0;
        chk1("req_ready idle", req_ready, 1'b1);
        req_valid = 1'b1; req_write = w; addr_mode = md; addr = a; write_data = wd;
        @(negedge clk);
        req_valid = 1'b0;
        if (!w && hit) begin
            rd = m_extract(md, off, mem_get(line));
            chk1("hit resp_valid", resp_valid, 1'b1);
            chk("hit read_data", read_data, rd);
            chk1("hit mem_req", mem_req, 1'b0);
            m_touch(line);
            if (m_hit < CMAX) m_hit++;
        end else begin
            chk1("mem_req", mem_req, 1'b1);
            chk1("mem_we", mem_we, w);
            chk1("busy req_ready", req_ready, 1'b0);
            chk1("busy resp_valid", resp_valid, 1'b0);
            if (w) begin
                chk("wr mem_addr", mem_addr, a);
                chk("wr mem_mode", {29'd0, mem_addr_mode}, {29'd0, md});
                chk("wr mem_wdata", mem_wdata, wd);
            end else begin
                chk("fill mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("fill mem_mode", {29'd0, mem_addr_mode}, {29'd0, DATA_ADDR_MODE_W});
                if (m_miss < CMAX) m_miss++;
            end
            d = $urandom_range(0, 3);
            repeat (d) begin
                @(negedge clk);
                chk1("mem_req held", mem_req, 1'b1);
            end
            mem_ack   = 1'b1;
            mem_rdata = w ? $urandom : mem_get(line);
            @(negedge clk);
            mem_ack = 1'b0;
            chk1("done resp_valid", resp_valid, 1'b1);
            chk1("done mem_req", mem_req, 1'b0);
            chk1("done req_ready", req_ready, 1'b1);
            if (w) begin
                word = mem_get(line);
                if (md == DATA_ADDR_MODE_B || md == DATA_ADDR_MODE_BU) word[8*off +: 8] = wd[7:0];
                else word = wd;
                mem[line] = word;
                if (hit) m_touch(line);
            end else begin
                rd = m_extract(md, off, mem_get(line));
                chk("fill read_data", read_data, rd);
                m_insert(line);
            end
        end
        chk("hit_count", {27'd0, hit_count}, 32'(m_hit));
        chk("miss_count", {27'd0, miss_count}, 32'(m_miss));
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic [2:0]  ld_modes [4];
    logic [2:0]  st_modes [3];

    initial begin
        ld_modes[0] = DATA_ADDR_MODE_B; ld_modes[1] = DATA_ADDR_MODE_BU;
        ld_modes[2] = DATA_ADDR_MODE_W; ld_modes[3] = 3'b001;
        st_modes[0] = DATA_ADDR_MODE_B; st_modes[1] = DATA_ADDR_MODE_BU;
        st_modes[2] = DATA_ADDR_MODE_W;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; addr_mode = 3'b000;
        addr = 32'h0; write_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        m_reset();
        repeat (2) @(negedge clk);
        chk1("reset req_ready", req_ready, 1'b1);
        chk1("reset resp_valid", resp_valid, 1'b0);
        chk1("reset mem_req", mem_req, 1'b0);
        chk1("reset mem_we", mem_we, 1'b0);
        chk("reset read_data", read_data, 32'h0);
        chk("reset hit_count", {27'd0, hit_count}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sequence with literal expectations.
        mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h40, 32'h0, rd);
        chk("t1 LW 0x40", rd, 32'hDEAD_BEEF);
        chk("t1 miss_count", {27'd0, miss_count}, 32'd1);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h40, 32'h0, rd);
        chk("t2 hit_count", {27'd0, hit_count}, 32'd1);
        do_req(1'b0, DATA_ADDR_MODE_B, 32'h43, 32'h0, rd);
        chk("t3 LB 0x43", rd, 32'hFFFF_FFDE);
        do_req(1'b0, DATA_ADDR_MODE_BU, 32'h43, 32'h0, rd);
        chk("t3 LBU 0x43", rd, 32'h0000_00DE);
        do_req(1'b1, DATA_ADDR_MODE_B, 32'h41, 32'h0000_0055, rd);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h40, 32'h0, rd);
        chk("t4 LW after SB", rd, 32'hDEAD_55EF);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h00, 32'h0, rd);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h20, 32'h0, rd);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h00, 32'h0, rd);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h40, 32'h0, rd);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h00, 32'h0, rd);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h20, 32'h0, rd);
        chk("t5 hit_count", {27'd0, hit_count}, 32'd6);
        chk("t5 miss_count", {27'd0, miss_count}, 32'd5);

        // Async reset in the middle of a fill.
        chk1("t6 req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b0; addr_mode = DATA_ADDR_MODE_W; addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("t6 fill mem_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("t6 reset mem_req", mem_req, 1'b0);
        chk1("t6 reset req_ready", req_ready, 1'b1);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, DATA_ADDR_MODE_W, 32'h80, 32'h0, rd);
        chk("t6 miss_count", {27'd0, miss_count}, 32'd1);

        // Randomized traffic over 4 tags x 8 sets; counters saturate along the way.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic        w;
            logic [2:0]  md;
            a  = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            w  = ($urandom_range(0, 9) < 4);
            md = w ? st_modes[$urandom_range(0, 2)] : ld_modes[$urandom_range(0, 3)];
            do_req(w, md, a, $urandom, rd);
            if ($urandom_range(0, 4) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
                @(negedge clk);
                mem_ack = 1'b0;
                chk1("stray ack resp_valid", resp_valid, 1'b0);
                chk1("stray ack mem_req", mem_req, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
